dmem_wait: RTL and testbench

Parametrised data memory with a valid/ready request port, a programmable wait-state count and sub-word access (byte/half/word, signed/unsigned loads, byte-lane stores). It replaces the zero-latency data memory of the single-cycle CPU, so that a multi-cycle or pipelined core can stall on memory. It sits between the core's load/store path and word-organised storage. A single outstanding request is supported.

---
 rtl/dmem_pkg.sv | 72 +++++++
 rtl/dmem_wait_ram_be.sv | 29 ++
 rtl/dmem_wait.sv | 127 ++++++++++++
 tb/tb_dmem_wait.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the wait-state data memory.
// Holds size/state enums, byte-enable, store-lane and load-extract functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Misaligned half/word or the reserved size code.
    function automatic logic size_err(size_e size, logic [1:0] a);
        logic e;
        unique case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = a[0];
            SZ_WORD: e = |a;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] lane_mask(size_e size, logic [1:0] a);
        logic [3:0] m;
        unique case (size)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data so every lane sees its byte.
    function automatic logic [31:0] store_lanes(logic [31:0] d, size_e size);
        logic [31:0] w;
        unique case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(
        logic [31:0] word,
        size_e       size,
        logic [1:0]  a,
        logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        unique case (size)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            SZ_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_wait_ram_be.sv
// ram_be: DEPTH x DATA_W synchronous RAM with per-byte write enables.
// Ports: clk, re (registered read), we_be[3:0], idx, wdata, q (old data).
module ram_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [3:0]               we_be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            q <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_wait.sv
// dmem_wait: data memory with valid/ready request, LATENCY wait states,
// sub-word loads/stores. Ports: clk, reset (async low), req_*, rsp_*.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    state_e            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              lat_we, lat_uns;
    size_e             lat_size;
    logic [AW+1:0]     lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              hs, err, busy_rsp;
    logic [3:0]        be;
    logic [DATA_W-1:0] ram_q;
    logic              unused_addr;

    // Address bits above the storage window alias.
    assign unused_addr = ^req_addr[31:AW+2];

    assign hs = req_valid & req_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= (state == RESP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (hs) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= size_e'(req_size);
            lat_addr  <= req_addr[AW+1:0];
            lat_wdata <= req_wdata;
        end
    end

    assign busy_rsp = (state == RESP);
    assign err      = size_err(lat_size, lat_addr[1:0]);
    assign be       = (busy_rsp && lat_we && !err)
                    ? lane_mask(lat_size, lat_addr[1:0]) : 4'b0000;

    ram_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .re    (busy_rsp),
        .we_be (be),
        .idx   (lat_addr[AW+1:2]),
        .wdata (store_lanes(lat_wdata, lat_size)),
        .q     (ram_q)
    );

    // Latched fields stay stable through the response cycle because
    // the next handshake can only land on the edge that ends it.
    always_comb begin
        rsp_rdata = '0;
        if (rsp_valid && !lat_we && !err) begin
            rsp_rdata = load_extract(ram_q, lat_size, lat_addr[1:0], lat_uns);
        end
    end

    assign rsp_err = rsp_valid & err;

endmodule

// File: tb/tb_dmem_wait.sv
// tb_dmem_wait: random + directed checks of dmem_wait against a byte-level
// memory model, for a LATENCY=2 instance (0) and a LATENCY=0 instance (1).
module tb_dmem_wait;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [1:0]  req_size [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];

    logic [31:0] mdl [2][64];
    int n_chk  = 0;
    int n_fail = 0;

    dmem_wait #(.DATA_W(32), .DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_wait #(.DATA_W(32), .DEPTH(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic mdl_err(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
               (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] mdl_load(int d, logic [1:0] sz,
                                             logic uns, logic [31:0] a);
        int n, lane, idx;
        logic [31:0] v;
        n   = 1 << sz;
        idx = int'(a[7:2]);
        v   = 0;
        for (int b = 0; b < n; b++) begin
            lane = int'(a[1:0]) + b;
            v = v | (((mdl[d][idx] >> (8 * lane)) & 32'hFF) << (8 * b));
        end
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    task automatic mdl_store(int d, logic [1:0] sz, logic [31:0] a,
                             logic [31:0] wd);
        int n, lane, idx;
        n   = 1 << sz;
        idx = int'(a[7:2]);
        for (int b = 0; b < n; b++) begin
            lane = int'(a[1:0]) + b;
            mdl[d][idx][8*lane +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic idle_inputs(int d);
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'b0;
        req_size[d]     = 2'd0;
        req_unsigned[d] = 1'b0;
        req_addr[d]     = 32'd0;
        req_wdata[d]    = 32'd0;
    endtask

    // One full transaction; called and returns at a negedge with DUT idle.
    task automatic do_req(input int d, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int lat, k;
        logic        e_err;
        logic [31:0] e_rd;
        lat   = (d == 0) ? 2 : 0;
        e_err = mdl_err(sz, a);
        e_rd  = (we || e_err) ? 32'd0 : mdl_load(d, sz, uns, a);
        chk("ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_addr[d]     = a;
        req_wdata[d]    = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'($urandom);
        req_size[d]     = 2'($urandom);
        req_unsigned[d] = 1'($urandom);
        req_addr[d]     = $urandom;
        req_wdata[d]    = $urandom;
        k = 0;
        while (!rsp_valid[d] && k < 20) begin
            chk("busy_ready", 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(lat + 1));
        rd = rsp_rdata[d];
        er = rsp_err[d];
        chk("rsp_err", 32'(er), 32'(e_err));
        chk("rsp_rdata", rd, e_rd);
        if (we && !e_err) mdl_store(d, sz, a, wd);
        @(posedge clk);
        @(negedge clk);
        chk("rsp_pulse", 32'(rsp_valid[d]), 32'd0);
    endtask

    logic [31:0] rd, old20, pat;
    logic        er;

    initial begin
        idle_inputs(0);
        idle_inputs(1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'd0);
            chk("rst_err", 32'(rsp_err[d]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                do_req(d, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd, er);

        do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, er);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, er);
        chk("dir_ldw", rd, 32'hDEADBEEF);
        do_req(0, 1, 2'd0, 0, 32'h11, 32'h0000007F, rd, er);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, er);
        chk("dir_byte_merge", rd, 32'hDEAD7FEF);
        do_req(0, 0, 2'd0, 0, 32'h13, 32'h0, rd, er);
        chk("dir_lb", rd, 32'hFFFFFFDE);
        do_req(0, 0, 2'd0, 1, 32'h13, 32'h0, rd, er);
        chk("dir_lbu", rd, 32'h000000DE);
        do_req(0, 0, 2'd1, 0, 32'h12, 32'h0, rd, er);
        chk("dir_lh", rd, 32'hFFFFDEAD);
        do_req(0, 1, 2'd2, 0, 32'h12, 32'h12345678, rd, er);
        chk("dir_sw_mis_err", 32'(er), 32'd1);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, er);
        chk("dir_sw_mis_keep", rd, 32'hDEAD7FEF);
        do_req(0, 0, 2'd1, 0, 32'h11, 32'h0, rd, er);
        chk("dir_lh_mis_err", 32'(er), 32'd1);
        chk("dir_lh_mis_data", rd, 32'd0);
        do_req(0, 0, 2'd3, 0, 32'h10, 32'h0, rd, er);
        chk("dir_bad_size", 32'(er), 32'd1);

        // Reset mid-WAIT must drop the pending store silently.
        old20 = mdl[0][8];
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_size[0]  = 2'd2;
        req_addr[0]  = 32'h20;
        req_wdata[0] = ~old20;
        @(posedge clk);
        @(negedge clk);
        idle_inputs(0);
        chk("abort_busy", 32'(req_ready[0]), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_valid", 32'(rsp_valid[0]), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        do_req(0, 0, 2'd2, 0, 32'h20, 32'h0, rd, er);
        chk("abort_no_write", rd, old20);

        // LATENCY=0: aliasing and back-to-back throughput.
        do_req(1, 1, 2'd2, 0, 32'h100, 32'hCAFEF00D, rd, er);
        do_req(1, 0, 2'd2, 0, 32'h000, 32'h0, rd, er);
        chk("alias", rd, 32'hCAFEF00D);

        pat = mdl_load(1, 2'd2, 1'b0, 32'h40);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_size[1]  = 2'd2;
        req_addr[1]  = 32'h40;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready", 32'(req_ready[1]), 32'(i % 2 == 0));
            chk("b2b_valid", 32'(rsp_valid[1]),
                32'(i >= 2 && i % 2 == 0));
            if (rsp_valid[1]) chk("b2b_data", rsp_rdata[1], pat);
            @(posedge clk);
            @(negedge clk);
        end
        idle_inputs(1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_drain", 32'(rsp_valid[1]), 32'd0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                logic [1:0]  sz;
                logic [31:0] a;
                sz = 2'($urandom_range(0, 3));
                a  = $urandom;
                if ($urandom_range(0, 2) != 0)
                    a = (sz == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
                do_req(d, 1'($urandom), sz, 1'($urandom), a, $urandom,
                       rd, er);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
